// File: rtl/dac_spi_pkg.sv
// Shared definitions for the quad 12-bit serial DAC frame format.
// The DAC interface master uses the same definitions.
package dac_spi_pkg;

  localparam int FRAME_BITS = 32;

  localparam logic [3:0] CMD_WRITE_IN     = 4'b0000;
  localparam logic [3:0] CMD_UPDATE       = 4'b0001;
  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] CMD_POWER_DOWN   = 4'b0100;

  localparam logic [3:0] ADDR_ALL = 4'hF;

  localparam int CMD_MSB  = 23;
  localparam int CMD_LSB  = 20;
  localparam int ADDR_MSB = 19;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } resp_state_t;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [3:0]  addr;
    logic [11:0] data;
  } frame_fields_t;

  function automatic frame_fields_t decode_frame(input logic [FRAME_BITS-1:0] frame);
    frame_fields_t f;
    f.cmd  = frame[CMD_MSB:CMD_LSB];
    f.addr = frame[ADDR_MSB:ADDR_LSB];
    f.data = frame[DATA_MSB:DATA_LSB];
    return f;
  endfunction

  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [3:0] cmd,
                                                       input logic [3:0] addr,
                                                       input logic [11:0] data);
    return {8'h00, cmd, addr, data, 4'h0};
  endfunction

endpackage

// File: rtl/dac_spi_responder_if.sv
// Serial bus between the DAC interface master and the DAC (or its responder model).
interface dac_spi_responder_if;
  logic SPI_SCK;
  logic SPI_MOSI;
  logic DAC_CS;
  logic DAC_CLR;
  logic SPI_MISO;

  modport master (
    output SPI_SCK, SPI_MOSI, DAC_CS, DAC_CLR,
    input  SPI_MISO
  );

  modport slave (
    input  SPI_SCK, SPI_MOSI, DAC_CS, DAC_CLR,
    output SPI_MISO
  );
endinterface

// File: rtl/dac_spi_responder_sync_edge.sv
// Two-flop synchronizer with a third stage used only for edge detection.
module sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
      s3 <= RESET_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/dac_spi_responder.sv
// SPI slave model of the quad 12-bit DAC: deserializes frames, keeps channel registers.
// Define DAC_RESP_ECHO_EN to echo the previous good frame on SPI_MISO.
module dac_spi_responder
  import dac_spi_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic                CLK_IN,
  input  logic                RST_N,
  dac_spi_responder_if.slave  spi,
  output logic                FRAME_VALID,
  output logic                FRAME_ERR,
  output logic [3:0]          CMD_OUT,
  output logic [3:0]          ADDR_OUT,
  output logic [11:0]         DATA_OUT,
  output logic [12*NUM_CH-1:0] VOUT,
  output logic [NUM_CH-1:0]   PWR_DN
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);

  logic sck_lvl_unused, sck_rise, sck_fall;
  logic cs_lvl_unused, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;
  logic clr_lvl, clr_rise_unused, clr_fall_unused;

  sync_edge #(.RESET_VAL(1'b0)) u_sync_sck (
    .clk(CLK_IN), .rst_n(RST_N), .din(spi.SPI_SCK),
    .level(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
  );
  sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk(CLK_IN), .rst_n(RST_N), .din(spi.DAC_CS),
    .level(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
  );
  sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk(CLK_IN), .rst_n(RST_N), .din(spi.SPI_MOSI),
    .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );
  sync_edge #(.RESET_VAL(1'b1)) u_sync_clr (
    .clk(CLK_IN), .rst_n(RST_N), .din(spi.DAC_CLR),
    .level(clr_lvl), .rise(clr_rise_unused), .fall(clr_fall_unused)
  );

  resp_state_t           state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic [11:0]           in_reg  [NUM_CH];
  logic [11:0]           out_reg [NUM_CH];
  frame_fields_t         fields;

`ifdef DAC_RESP_ECHO_EN
  logic [FRAME_BITS-1:0] echo_sr;
  logic [FRAME_BITS-1:0] last_frame;
`endif

  assign fields = decode_frame(shreg);

  // A frame is accepted only with an exact bit count; the CLR hold is applied
  // last so it overrides any register write from a frame finishing alongside it.
  always_ff @(posedge CLK_IN) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      FRAME_VALID <= 1'b0;
      FRAME_ERR   <= 1'b0;
      CMD_OUT     <= '0;
      ADDR_OUT    <= '0;
      DATA_OUT    <= '0;
      PWR_DN      <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        in_reg[n]  <= '0;
        out_reg[n] <= '0;
      end
`ifdef DAC_RESP_ECHO_EN
      echo_sr    <= '0;
      last_frame <= '0;
`endif
    end else begin
      FRAME_VALID <= 1'b0;
      FRAME_ERR   <= 1'b0;
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
`ifdef DAC_RESP_ECHO_EN
          echo_sr <= last_frame;
`endif
          if (cs_fall) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (sck_rise) begin
            shreg <= {shreg[FRAME_BITS-2:0], mosi_lvl};
            if (bit_cnt != CNT_W'(FRAME_BITS + 1)) bit_cnt <= bit_cnt + 1'b1;
          end
`ifdef DAC_RESP_ECHO_EN
          if (sck_fall) echo_sr <= {echo_sr[FRAME_BITS-2:0], 1'b0};
`endif
          if (cs_rise) state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          if (bit_cnt == CNT_W'(FRAME_BITS)) begin
            FRAME_VALID <= 1'b1;
            CMD_OUT     <= fields.cmd;
            ADDR_OUT    <= fields.addr;
            DATA_OUT    <= fields.data;
`ifdef DAC_RESP_ECHO_EN
            last_frame  <= shreg;
`endif
            for (int n = 0; n < NUM_CH; n++) begin
              if (fields.addr == ADDR_ALL || fields.addr == 4'(n)) begin
                case (fields.cmd)
                  CMD_WRITE_IN: in_reg[n] <= fields.data;
                  CMD_UPDATE: begin
                    out_reg[n] <= in_reg[n];
                    PWR_DN[n]  <= 1'b0;
                  end
                  CMD_WRITE_UPDATE: begin
                    in_reg[n]  <= fields.data;
                    out_reg[n] <= fields.data;
                    PWR_DN[n]  <= 1'b0;
                  end
                  CMD_POWER_DOWN: PWR_DN[n] <= 1'b1;
                  default: ;
                endcase
              end
            end
          end else begin
            FRAME_ERR <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (!clr_lvl) begin
        for (int n = 0; n < NUM_CH; n++) begin
          in_reg[n]  <= '0;
          out_reg[n] <= '0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_vout
    assign VOUT[12*g +: 12] = out_reg[g];
  end

`ifdef DAC_RESP_ECHO_EN
  assign spi.SPI_MISO = echo_sr[FRAME_BITS-1];
`else
  assign spi.SPI_MISO = 1'b0;
`endif

endmodule

// File: tb/tb_dac_spi_responder.sv
// Directed self-checking bench for dac_spi_responder (echo expectations follow DAC_RESP_ECHO_EN).
module tb_dac_spi_responder;
  import dac_spi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        frame_valid, frame_err;
  logic [3:0]  cmd_out, addr_out;
  logic [11:0] data_out;
  logic [47:0] vout;
  logic [3:0]  pwr_dn;

  dac_spi_responder_if spi ();

  dac_spi_responder #(.NUM_CH(4)) dut (
    .CLK_IN(clk), .RST_N(rst_n), .spi(spi),
    .FRAME_VALID(frame_valid), .FRAME_ERR(frame_err),
    .CMD_OUT(cmd_out), .ADDR_OUT(addr_out), .DATA_OUT(data_out),
    .VOUT(vout), .PWR_DN(pwr_dn)
  );

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int lat;
  logic [47:0] vout_at_valid;
  logic [31:0] miso_cap;
  logic [31:0] echo_exp;

  always @(negedge clk) begin
    if (frame_valid) begin
      valid_cnt++;
      vout_at_valid = vout;
    end
    if (frame_err) err_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    spi.DAC_CS = 1'b0;
    valid_cnt = 0;
    err_cnt = 0;
    cyc(4);
  endtask

  // Each bit: 4 cycles low (MISO sampled at the end), 4 cycles high.
  task automatic send_bits(input logic [63:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      int k;
      k = n - 1 - i;
      spi.SPI_MOSI = w[i];
      cyc(4);
      if (k < 32) miso_cap[31-k] = spi.SPI_MISO;
      spi.SPI_SCK = 1'b1;
      cyc(4);
      spi.SPI_SCK = 1'b0;
    end
    cyc(4);
  endtask

  task automatic cs_high();
    spi.DAC_CS = 1'b1;
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      if (lat < 0 && (frame_valid || frame_err)) lat = i;
    end
  endtask

  task automatic send_frame(input logic [3:0] c, input logic [3:0] a, input logic [11:0] d);
    cs_low();
    send_bits({32'h0, make_frame(c, a, d)}, 32);
    cs_high();
  endtask

  task automatic chk_pulses(input string name, input int exp_v, input int exp_e);
    checks++;
    if (valid_cnt !== exp_v || err_cnt !== exp_e) begin
      errors++;
      $display("[TB] FAIL %s pulses: valid=%0d err=%0d, required valid=%0d err=%0d",
               name, valid_cnt, err_cnt, exp_v, exp_e);
    end
  endtask

  task automatic chk_vout(input string name, input logic [47:0] exp);
    checks++;
    if (vout !== exp) begin
      errors++;
      $display("[TB] FAIL %s vout: got %h, required %h", name, vout, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    spi.SPI_SCK = 1'b0; spi.SPI_MOSI = 1'b0; spi.DAC_CS = 1'b1; spi.DAC_CLR = 1'b1;
    cyc(3);
    checks++;
    if ({frame_valid, frame_err, cmd_out, addr_out, data_out, vout, pwr_dn, spi.SPI_MISO} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got v=%b e=%b cmd=%h addr=%h data=%h vout=%h pd=%b miso=%b, required all 0",
               frame_valid, frame_err, cmd_out, addr_out, data_out, vout, pwr_dn, spi.SPI_MISO);
    end
    rst_n = 1'b1;
    cyc(3);
  endtask

  task automatic test_write_update();
    send_frame(4'h3, 4'h1, 12'hABC);
    chk_pulses("write_update", 1, 0);
    checks++;
    if (cmd_out !== 4'h3 || addr_out !== 4'h1 || data_out !== 12'hABC) begin
      errors++;
      $display("[TB] FAIL write_update_fields: got %h/%h/%h, required 3/1/abc", cmd_out, addr_out, data_out);
    end
    chk_vout("write_update", 48'h000000ABC000);
    checks++;
    if (vout_at_valid !== 48'h000000ABC000) begin
      errors++;
      $display("[TB] FAIL vout_with_valid: got %h, required %h", vout_at_valid, 48'h000000ABC000);
    end
    checks++;
    if (lat < 1 || lat > 4) begin
      errors++;
      $display("[TB] FAIL latency: got %0d cycles, required 1..4", lat);
    end
  endtask

  task automatic test_update();
    send_frame(4'h0, 4'h2, 12'h123);
    chk_pulses("write_in", 1, 0);
    chk_vout("write_in", 48'h000000ABC000);
    send_frame(4'h1, 4'h2, 12'h000);
    chk_pulses("update", 1, 0);
    chk_vout("update", 48'h000123ABC000);
  endtask

  task automatic test_broadcast();
    send_frame(4'h3, 4'hF, 12'h7FF);
    chk_vout("broadcast", 48'h7FF7FF7FF7FF);
    send_frame(4'h4, 4'h0, 12'h000);
    checks++;
    if (pwr_dn !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL power_down: got %b, required 0001", pwr_dn);
    end
    chk_vout("power_down", 48'h7FF7FF7FF7FF);
    send_frame(4'h3, 4'h5, 12'h555);
    chk_pulses("bad_addr", 1, 0);
    chk_vout("bad_addr", 48'h7FF7FF7FF7FF);
    checks++;
    if (addr_out !== 4'h5 || data_out !== 12'h555) begin
      errors++;
      $display("[TB] FAIL bad_addr_fields: got addr=%h data=%h, required 5/555", addr_out, data_out);
    end
    send_frame(4'h0, 4'h0, 12'h111);
    send_frame(4'h1, 4'h0, 12'h000);
    chk_vout("update_ch0", 48'h7FF7FF7FF111);
    checks++;
    if (pwr_dn !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL power_up: got %b, required 0000", pwr_dn);
    end
  endtask

  task automatic test_bad_count();
    logic [31:0] f;
    f = make_frame(4'h3, 4'h2, 12'hFFF);
    cs_low();
    send_bits({33'h0, f[31:1]}, 31);
    cs_high();
    chk_pulses("short_frame", 0, 1);
    chk_vout("short_frame", 48'h7FF7FF7FF111);
    checks++;
    if (cmd_out !== 4'h1 || addr_out !== 4'h0) begin
      errors++;
      $display("[TB] FAIL short_frame_fields: got cmd=%h addr=%h, required 1/0", cmd_out, addr_out);
    end
    cs_low();
    send_bits({31'h0, f, 1'b0}, 33);
    cs_high();
    chk_pulses("long_frame", 0, 1);
    chk_vout("long_frame", 48'h7FF7FF7FF111);
  endtask

  task automatic test_clear();
    send_frame(4'h4, 4'h3, 12'h000);
    spi.DAC_CLR = 1'b0;
    cyc(3);
    chk_vout("clear_3cyc", 48'h0);
    cyc(7);
    spi.DAC_CLR = 1'b1;
    cyc(4);
    checks++;
    if (pwr_dn !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL clear_pwr_dn: got %b, required 1000", pwr_dn);
    end
    send_frame(4'h1, 4'hF, 12'h000);
    chk_vout("clear_inputs", 48'h0);
    spi.DAC_CLR = 1'b0;
    send_frame(4'h3, 4'h1, 12'hABC);
    chk_pulses("frame_in_clear", 1, 0);
    chk_vout("frame_in_clear", 48'h0);
    spi.DAC_CLR = 1'b1;
    cyc(4);
  endtask

  task automatic test_reset_mid_frame();
    send_frame(4'h3, 4'h0, 12'h456);
    chk_vout("pre_reset", 48'h000000000456);
    cs_low();
    send_bits({32'h0, make_frame(4'h3, 4'h1, 12'h999)}, 10);
    rst_n = 1'b0;
    cyc(2);
    spi.DAC_CS = 1'b1;
    cyc(2);
    checks++;
    if ({cmd_out, addr_out, data_out, vout, pwr_dn} !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got cmd=%h addr=%h data=%h vout=%h pd=%b, required 0",
               cmd_out, addr_out, data_out, vout, pwr_dn);
    end
    rst_n = 1'b1;
    cyc(12);
    chk_pulses("mid_reset", 0, 0);
  endtask

  task automatic test_echo();
    logic [31:0] fa;
    fa = make_frame(4'h3, 4'h1, 12'hABC);
    send_frame(4'h3, 4'h1, 12'hABC);
    checks++;
    if (miso_cap !== 32'h0) begin
      errors++;
      $display("[TB] FAIL echo_first: got %h, required 00000000", miso_cap);
    end
    send_frame(4'h3, 4'h2, 12'h123);
`ifdef DAC_RESP_ECHO_EN
    echo_exp = fa;
`else
    echo_exp = 32'h0;
`endif
    checks++;
    if (miso_cap !== echo_exp) begin
      errors++;
      $display("[TB] FAIL echo_second: got %h, required %h", miso_cap, echo_exp);
    end
    chk_vout("echo_frames", 48'h000123ABC000);
  endtask

  initial begin
    test_reset();
    test_write_update();
    test_update();
    test_broadcast();
    test_bad_count();
    test_clear();
    test_reset_mid_frame();
    test_echo();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
